instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, value presented on instr_pc while no instruction has been fetched.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, value of instr after reset and after flush (addi x0,x0,0).
REQ-003 Parameter TIMEOUT_CYCLES, 16, wait-cycle limit in REQ (used only under REQ-029).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clr  input  1  reset; asynchronous, active-high.
REQ-006 pc_val  input  32  current fetch address from the program counter.
REQ-007 stall  input  1  downstream hold; blocks issue of new fetches.
REQ-008 flush  input  1  branch/jump redirect; discards in-flight and held instructions.
REQ-009 mem_ready  input  1  instruction memory has mem_rdata valid for current mem_addr.
REQ-010 mem_rdata  input  32  instruction word from memory.
REQ-011 instr_ready  input  1  decode stage accepts instr this cycle.
REQ-012 mem_req  output  1  fetch request to instruction memory.
REQ-013 mem_addr  output  32  registered fetch address, word-aligned.
REQ-014 instr  output  32  fetched instruction word.
REQ-015 instr_pc  output  32  address instr was fetched from.
REQ-016 instr_valid  output  1  instr/instr_pc valid for decode.
REQ-017 pc_inc  output  1  one-cycle pulse driving the PC inc input.
REQ-018 fetch_err  output  1  sticky error flag (misalign or timeout).

Function
REQ-019 FSM states IDLE, REQ, VALID; encoding free; mem_req=1 only in REQ, instr_valid=1 only in VALID.
REQ-020 IDLE: if !stall and !flush, next state REQ and mem_addr <= {pc_val[31:2],2'b00}; else stay IDLE.
REQ-021 REQ: mem_addr held stable; on mem_ready && !flush, instr <= mem_rdata, instr_pc <= mem_addr, next state VALID.
REQ-022 pc_inc SHALL be combinational = (state==REQ) && mem_ready && !flush, so the PC advances on the same edge the word is captured.
REQ-023 VALID: instr/instr_pc held until instr_ready; on instr_ready && !stall next state REQ with mem_addr <= aligned pc_val (back-to-back, one fetch per two cycles minimum); on instr_ready && stall next state IDLE; without instr_ready stay VALID regardless of stall.
REQ-024 Fetch latency: mem_ready in cycle N -> instr_valid high in cycle N+1.
REQ-025 flush in any state: next state IDLE, instr <= NOP_INSTR, instr_valid low next cycle, no pc_inc; flush has priority over mem_ready, instr_ready and stall in the same cycle.
REQ-026 Misalign: if pc_val[1:0]!=0 when a fetch is issued, fetch_err <= 1; fetch proceeds at aligned address.
REQ-027 fetch_err clears only on clr.

Reset
REQ-028 While clr=1: state IDLE, mem_req=0, mem_addr=0, instr=NOP_INSTR, instr_pc=RESET_PC, instr_valid=0, pc_inc=0, fetch_err=0; reset mid-REQ abandons the request with no pc_inc.

Configuration
REQ-029 Macro FETCH_TIMEOUT_EN defined: a wait counter counts REQ cycles without mem_ready; reaching TIMEOUT_CYCLES sets fetch_err, loads instr=NOP_INSTR, instr_pc=mem_addr, enters VALID, pulses pc_inc; counter clears on leaving REQ. Undefined: no counter, REQ waits indefinitely, fetch_err set only by misalign.

Verification
REQ-030 Reset then pc_val=0, mem_ready=1 from cycle 2, instr_ready=1, mem_rdata=32'h00500093 -> mem_addr=0, pc_inc one pulse, instr=32'h00500093, instr_pc=0 next cycle.
REQ-031 Back-to-back: pc_val 0 then 4, mem_ready=1, instr_ready=1 -> instr_pc sequence 0,4,8 with exactly one pc_inc per fetch.
REQ-032 Hold: instr_valid=1, instr_ready=0 for 3 cycles, mem_rdata changed -> instr, instr_pc unchanged, mem_req=0.
REQ-033 Flush and mem_ready same cycle in REQ -> pc_inc=0, next cycle state IDLE, instr=32'h00000013, instr_valid=0.
REQ-034 pc_val=32'h0000_0006 issued -> mem_addr=32'h0000_0004, fetch_err=1 and stays 1 until clr.
REQ-035 FETCH_TIMEOUT_EN, mem_ready=0 for 16 REQ cycles -> fetch_err=1, instr=32'h00000013, instr_valid=1, one pc_inc; without macro, mem_req stays high for 20+ cycles.

Source files
------------

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Purpose:
//   Instruction fetch stage. Issues one word-aligned request to instruction
//   memory at a time, captures the returned word together with the address
//   it came from, and presents it to decode with a valid/ready handshake.
//   A flush discards whatever is in flight or held and replaces the
//   presented instruction with a NOP. A misaligned fetch address raises a
//   sticky error flag; the fetch still goes ahead at the aligned address.
//
// Configuration:
//   FETCH_TIMEOUT_EN  - when defined, a wait counter watches the request
//                       phase; after TIMEOUT_CYCLES cycles without
//                       mem_ready the stage gives up, raises fetch_err and
//                       hands a NOP (tagged with the requested address) to
//                       decode. When undefined the request waits forever.
//
// Parameters:
//   RESET_PC        - instr_pc value while nothing has been fetched
//   NOP_INSTR       - instruction presented after reset and after flush
//   TIMEOUT_CYCLES  - request wait limit (FETCH_TIMEOUT_EN only)
//
// Ports:
//   clk          in   clock, rising edge
//   clr          in   asynchronous active-high reset
//   pc_val       in   32  current fetch address from the PC
//   stall        in   downstream hold, blocks issue of new fetches
//   flush        in   redirect, discards in-flight and held instructions
//   mem_ready    in   mem_rdata is valid for mem_addr
//   mem_rdata    in   32  instruction word from memory
//   instr_ready  in   decode accepts instr this cycle
//   mem_req      out  fetch request to memory
//   mem_addr     out  32  registered word-aligned fetch address
//   instr        out  32  fetched instruction word
//   instr_pc     out  32  address instr was fetched from
//   instr_valid  out  instr/instr_pc valid for decode
//   pc_inc       out  one-cycle pulse advancing the PC
//   fetch_err    out  sticky misalign / timeout error
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] pc_val,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        instr_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        pc_inc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        err_q, err_d;
    logic        pc_inc_c;

    logic [31:0] alignedPc;
    logic        misaligned;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout;
`else
    // The wait limit has no effect when the watchdog is compiled out; this
    // keeps the parameter referenced so both builds share one interface.
    localparam int unsigned unusedTimeout = TIMEOUT_CYCLES;
`endif

    assign alignedPc  = {pc_val[31:2], 2'b00};
    assign misaligned = |pc_val[1:0];

    // Next-state and datapath decisions. Flush is checked first so it wins
    // over mem_ready, instr_ready and stall arriving in the same cycle, and
    // it suppresses pc_inc because the captured word would be thrown away.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        err_d      = err_q;
        pc_inc_c   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_d     = '0;
        timeout    = (state_q == REQ) && !mem_ready &&
                     (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
`endif

        if (flush) begin
            state_d = IDLE;
            instr_d = NOP_INSTR;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stall) begin
                        state_d    = REQ;
                        mem_addr_d = alignedPc;
                        if (misaligned) begin
                            err_d = 1'b1;
                        end
                    end
                end
                REQ: begin
                    // pc_inc fires on the same edge the word is captured so
                    // pc_val already points at the next word when decode
                    // hands back instr_ready.
                    if (mem_ready) begin
                        instr_d    = mem_rdata;
                        instr_pc_d = mem_addr_q;
                        state_d    = VALID;
                        pc_inc_c   = 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (timeout) begin
                        instr_d    = NOP_INSTR;
                        instr_pc_d = mem_addr_q;
                        err_d      = 1'b1;
                        state_d    = VALID;
                        pc_inc_c   = 1'b1;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
`endif
                end
                VALID: begin
                    if (instr_ready) begin
                        if (!stall) begin
                            state_d    = REQ;
                            mem_addr_d = alignedPc;
                            if (misaligned) begin
                                err_d = 1'b1;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            mem_addr_q <= 32'h0000_0000;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            err_q      <= err_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Wait counter; clears whenever the stage is not waiting in REQ.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign mem_req     = (state_q == REQ);
    assign instr_valid = (state_q == VALID);
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = err_q;
    assign pc_inc      = pc_inc_c;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. A transaction-level model tracks whether a
// fetch is outstanding and whether a word is being offered to decode, and a
// compare process checks every DUT output against it on each falling edge.
// Hand-computed literal checks after key steps pin the model itself.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TO  = 16;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] pc_val;
    logic        stall;
    logic        flush;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        instr_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        pc_inc;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;
    int incCount = 0;
    bit checkEn  = 1'b0;

    // Model: a fetch is either outstanding at memory, offered to decode, or
    // neither. Values start at their reset state.
    bit          mBusy  = 1'b0;
    bit          mHave  = 1'b0;
    bit          mErr   = 1'b0;
    logic [31:0] mAddr  = 32'h0;
    logic [31:0] mInstr = NOP;
    logic [31:0] mPc    = 32'h0;
    int          mWait  = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC       (32'h0000_0000),
        .NOP_INSTR      (NOP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .pc_val      (pc_val),
        .stall       (stall),
        .flush       (flush),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .instr_ready (instr_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .pc_inc      (pc_inc),
        .fetch_err   (fetch_err)
    );

    // True on the cycle a waiting fetch gives up (watchdog builds only).
    function automatic bit modelTimeout();
`ifdef FETCH_TIMEOUT_EN
        return mBusy && !mem_ready && (mWait + 1 >= TO);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void modelIssue();
        mBusy = 1'b1;
        mAddr = pc_val & 32'hFFFF_FFFC;
        if (pc_val[1:0] != 2'b00) mErr = 1'b1;
        mWait = 0;
    endfunction

    // Model update on each edge from the rules of the fetch protocol.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            mBusy = 1'b0; mHave = 1'b0; mErr = 1'b0;
            mAddr = 32'h0; mInstr = NOP; mPc = 32'h0; mWait = 0;
        end else if (flush) begin
            mBusy = 1'b0; mHave = 1'b0; mInstr = NOP; mWait = 0;
        end else if (mBusy) begin
            if (mem_ready) begin
                mInstr = mem_rdata; mPc = mAddr;
                mBusy = 1'b0; mHave = 1'b1; mWait = 0;
            end else if (modelTimeout()) begin
                mInstr = NOP; mPc = mAddr; mErr = 1'b1;
                mBusy = 1'b0; mHave = 1'b1; mWait = 0;
            end else begin
                mWait = mWait + 1;
            end
        end else if (mHave) begin
            if (instr_ready) begin
                mHave = 1'b0;
                if (!stall) modelIssue();
            end
        end else if (!stall) begin
            modelIssue();
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every output against the model on every falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("mem_req",     32'(mem_req),     32'(mBusy));
            checkOutput("mem_addr",    mem_addr,         mAddr);
            checkOutput("instr",       instr,            mInstr);
            checkOutput("instr_pc",    instr_pc,         mPc);
            checkOutput("instr_valid", 32'(instr_valid), 32'(mHave));
            checkOutput("fetch_err",   32'(fetch_err),   32'(mErr));
            checkOutput("pc_inc",      32'(pc_inc),
                        32'(!clr && mBusy && !flush && (mem_ready || modelTimeout())));
        end
        if (pc_inc === 1'b1) incCount++;
    end

    // One cycle of inputs, returning just after the following rising edge.
    task automatic applyStimulus(input bit rst, input bit stl, input bit fl,
                                 input bit mr, input logic [31:0] rd,
                                 input bit ir, input logic [31:0] pc);
        clr         = rst;
        stall       = stl;
        flush       = fl;
        mem_ready   = mr;
        mem_rdata   = rd;
        instr_ready = ir;
        pc_val      = pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; stall = 1'b0; flush = 1'b0; mem_ready = 1'b0;
        mem_rdata = 32'h0; instr_ready = 1'b0; pc_val = 32'h0;
        checkEn = 1'b1;

        // Reset
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("rst_instr",    instr,         NOP);
        checkOutput("rst_instr_pc", instr_pc,      32'h0);
        checkOutput("rst_valid",    32'(instr_valid), 32'h0);

        // First fetch from address 0
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h0);
        checkOutput("f0_mem_req",  32'(mem_req), 32'h1);
        checkOutput("f0_mem_addr", mem_addr,     32'h0);
        applyStimulus(0, 0, 0, 1, 32'h0050_0093, 1, 32'h0);
        checkOutput("f0_instr",    instr,            32'h0050_0093);
        checkOutput("f0_instr_pc", instr_pc,         32'h0);
        checkOutput("f0_valid",    32'(instr_valid), 32'h1);
        checkOutput("f0_incs",     32'(incCount),    32'd1);

        // Back-to-back fetches at 4 and 8
        applyStimulus(0, 0, 0, 1, 32'h0, 1, 32'h4);
        applyStimulus(0, 0, 0, 1, 32'hAAAA_0001, 1, 32'h4);
        checkOutput("b2b_pc4", instr_pc, 32'h4);
        applyStimulus(0, 0, 0, 1, 32'h0, 1, 32'h8);
        applyStimulus(0, 0, 0, 1, 32'hBBBB_0002, 1, 32'h8);
        checkOutput("b2b_pc8",  instr_pc,         32'h8);
        checkOutput("b2b_incs", 32'(incCount),    32'd3);

        // Hold while decode is not ready; memory data changes underneath
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 0, 1, 32'hDEAD_0000 + 32'(i), 0, 32'hC);
        checkOutput("hold_instr",   instr,         32'hBBBB_0002);
        checkOutput("hold_pc",      instr_pc,      32'h8);
        checkOutput("hold_mem_req", 32'(mem_req),  32'h0);

        // Accept under stall -> idle; then resume and wait in REQ
        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'hC);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'hC);
        checkOutput("stall_valid", 32'(instr_valid), 32'h0);
        checkOutput("stall_req",   32'(mem_req),     32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'hC);
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'hC);

        // Flush and mem_ready together in REQ
        applyStimulus(0, 0, 1, 1, 32'hCCCC_0003, 1, 32'hC);
        checkOutput("fl_instr", instr,            32'h0000_0013);
        checkOutput("fl_valid", 32'(instr_valid), 32'h0);
        checkOutput("fl_req",   32'(mem_req),     32'h0);
        checkOutput("fl_incs",  32'(incCount),    32'd3);

        // Misaligned fetch at 6
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h6);
        checkOutput("mis_addr", mem_addr,       32'h4);
        checkOutput("mis_err",  32'(fetch_err), 32'h1);
        applyStimulus(0, 0, 0, 1, 32'hDDDD_0004, 0, 32'h8);
        checkOutput("mis_pc", instr_pc, 32'h4);
        applyStimulus(0, 0, 1, 0, 32'h0, 1, 32'h8);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h8);
        applyStimulus(0, 1, 0, 0, 32'h0, 0, 32'h8);
        checkOutput("mis_sticky", 32'(fetch_err), 32'h1);

        // Reset in the middle of a request
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h8);
        applyStimulus(1, 0, 0, 1, 32'hEEEE_0005, 1, 32'h8);
        checkOutput("mid_rst_err",  32'(fetch_err), 32'h0);
        checkOutput("mid_rst_req",  32'(mem_req),   32'h0);
        checkOutput("mid_rst_incs", 32'(incCount),  32'd4);
        applyStimulus(1, 0, 0, 0, 32'h0, 0, 32'h8);

        // Memory never answers
        applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h10);
        for (int i = 0; i < 22; i++)
            applyStimulus(0, 0, 0, 0, 32'h0, 0, 32'h14);
`ifdef FETCH_TIMEOUT_EN
        checkOutput("to_valid", 32'(instr_valid), 32'h1);
        checkOutput("to_instr", instr,            32'h0000_0013);
        checkOutput("to_pc",    instr_pc,         32'h10);
        checkOutput("to_err",   32'(fetch_err),   32'h1);
        checkOutput("to_incs",  32'(incCount),    32'd5);
`else
        checkOutput("wait_req",   32'(mem_req),     32'h1);
        checkOutput("wait_valid", 32'(instr_valid), 32'h0);
        checkOutput("wait_err",   32'(fetch_err),   32'h0);
        checkOutput("wait_incs",  32'(incCount),    32'd4);
`endif
        applyStimulus(0, 0, 0, 1, 32'hFFFF_0006, 0, 32'h14);
        applyStimulus(0, 0, 0, 0, 32'h0, 1, 32'h14);
        applyStimulus(0, 1, 0, 0, 32'h0, 1, 32'h14);

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
